// File: rtl/morse_text_buffer_if.sv
// Handshake and display bundle between the Morse receive path,
// the text buffer and the screen renderer.
interface morse_text_buffer_if #(
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic                 char_valid;
    logic [7:0]           char_code;
    logic                 word_end;
    logic                 clear;
    logic [0:DEPTH*8-1]   data;
    logic [CW-1:0]        count;
    logic [PW-1:0]        cursor;
    logic                 full;
    logic                 wr_pulse;

    modport master (
        output char_valid, char_code, word_end, clear,
        input  data, count, cursor, full, wr_pulse
    );

    modport slave (
        input  char_valid, char_code, word_end, clear,
        output data, count, cursor, full, wr_pulse
    );
endinterface

// File: rtl/morse_text_buffer.sv
// Scrolling line buffer of decoded Morse characters with
// word-gap space insertion (no leading or doubled spaces).
module morse_text_buffer #(
    parameter int         DEPTH      = 32,
    parameter logic [7:0] SPACE_CODE = 8'h20,
    parameter logic [7:0] BLANK_CODE = 8'h00
) (
    input logic               clk,
    input logic               reset,
    morse_text_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, PEND_SPACE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    slots [DEPTH];
    logic [CW-1:0] count;
    logic          last_space;
    logic          wr_pulse;
    logic          wr_en;
    logic [7:0]    wr_code;
    logic          is_full;
    logic          space_ok;

    assign is_full  = (count == CW'(DEPTH));
    assign space_ok = (count != '0) && !last_space;

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A character arriving while a space is pending goes first;
    // the space waits for the first cycle without a character.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.char_valid && bus.word_end) begin
                    state_nx = PEND_SPACE;
                end
            end
            PEND_SPACE: begin
                if (!bus.char_valid) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_code = bus.char_code;
        if (!bus.clear) begin
            if (bus.char_valid) begin
                wr_en = 1'b1;
            end else if (bus.word_end || state == PEND_SPACE) begin
                wr_en   = space_ok;
                wr_code = SPACE_CODE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= BLANK_CODE;
            end
            count      <= '0;
            last_space <= 1'b0;
        end else if (wr_en) begin
            if (is_full) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slots[i] <= slots[i+1];
                end
                slots[DEPTH-1] <= wr_code;
            end else begin
                slots[count[PW-1:0]] <= wr_code;
                count                <= count + 1'b1;
            end
            last_space <= (wr_code == SPACE_CODE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr_en;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_data
        assign bus.data[8*g +: 8] = slots[g];
    end

    assign bus.count    = count;
    assign bus.cursor   = is_full ? PW'(DEPTH - 1) : count[PW-1:0];
    assign bus.full     = is_full;
    assign bus.wr_pulse = wr_pulse;
endmodule

// File: tb/tb_morse_text_buffer.sv
// Directed and randomized checks of morse_text_buffer against a
// queue-based model of the visible line.
module tb_morse_text_buffer;
    localparam int         DEPTH = 32;
    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] BL    = 8'h00;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    logic [7:0] q[$];
    bit         pend;
    bit         ls;
    bit         wrote;

    morse_text_buffer_if #(.DEPTH(DEPTH)) bus();

    morse_text_buffer #(
        .DEPTH(DEPTH),
        .SPACE_CODE(SP),
        .BLANK_CODE(BL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [DEPTH*8-1:0] obs,
                         input logic [DEPTH*8-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] c);
        q.push_back(c);
        if (q.size() > DEPTH) void'(q.pop_front());
        ls    = (c == SP);
        wrote = 1'b1;
    endtask

    task automatic model(input bit cv, input logic [7:0] code,
                         input bit we, input bit clr, input bit rst);
        wrote = 1'b0;
        if (rst || clr) begin
            q.delete();
            pend = 1'b0;
            ls   = 1'b0;
        end else if (cv) begin
            push(code);
            pend = pend | we;
        end else if (pend || we) begin
            pend = 1'b0;
            if (q.size() > 0 && !ls) push(SP);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [0:DEPTH*8-1] e;
        int n;
        n = q.size();
        for (int i = 0; i < DEPTH; i++)
            e[8*i +: 8] = (i < n) ? q[i] : BL;
        check({tag, ".data"}, bus.data, e);
        check({tag, ".count"}, bus.count, n);
        check({tag, ".cursor"}, bus.cursor,
              (n >= DEPTH) ? DEPTH - 1 : n);
        check({tag, ".full"}, bus.full, n == DEPTH);
        check({tag, ".wr_pulse"}, bus.wr_pulse, wrote);
    endtask

    task automatic step(input string tag, input bit cv,
                        input logic [7:0] code, input bit we,
                        input bit clr, input bit rst);
        bus.char_valid = cv;
        bus.char_code  = code;
        bus.word_end   = we;
        bus.clear      = clr;
        reset          = rst;
        @(posedge clk);
        model(cv, code, we, clr, rst);
        #1;
        bus.char_valid = 1'b0;
        bus.word_end   = 1'b0;
        bus.clear      = 1'b0;
        reset          = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] c;
        int         p;
        bit         cv;
        bit         we;
        bit         clr;
        bit         rst;
        pend = 1'b0;
        ls   = 1'b0;
        bus.char_code = 8'h00;

        step("reset", 0, 8'h00, 0, 0, 1);
        step("reset2", 0, 8'h00, 0, 0, 1);

        step("ab_a", 1, 8'h41, 0, 0, 0);
        step("ab_b", 1, 8'h42, 0, 0, 0);
        step("ab_idle", 0, 8'h00, 0, 0, 0);

        step("sp_clr", 0, 8'h00, 0, 1, 0);
        step("sp_lead", 0, 8'h00, 1, 0, 0);
        step("sp_a", 1, 8'h41, 0, 0, 0);
        step("sp_we1", 0, 8'h00, 1, 0, 0);
        step("sp_we2", 0, 8'h00, 1, 0, 0);

        step("pd_clr", 0, 8'h00, 0, 1, 0);
        step("pd_c", 1, 8'h43, 1, 0, 0);
        step("pd_sp", 0, 8'h00, 0, 0, 0);
        step("pd_clr2", 0, 8'h00, 0, 1, 0);
        step("pd_c2", 1, 8'h43, 1, 0, 0);
        step("pd_d", 1, 8'h44, 0, 0, 0);
        step("pd_sp2", 0, 8'h00, 0, 0, 0);
        step("pd_idle", 0, 8'h00, 0, 0, 0);
        step("pd_abs", 1, 8'h45, 1, 0, 0);
        step("pd_abs_we", 0, 8'h00, 1, 0, 0);
        step("pd_abs_idle", 0, 8'h00, 0, 0, 0);
        step("pd_spchar", 1, SP, 1, 0, 0);
        step("pd_spsupp", 0, 8'h00, 0, 0, 0);

        step("fill_clr", 0, 8'h00, 0, 1, 0);
        for (int i = 1; i <= 33; i++)
            step("fill", 1, 8'(i), 0, 0, 0);
        step("fill_blank", 1, BL, 0, 0, 0);

        step("mid_clr", 0, 8'h00, 0, 1, 0);
        step("mid_a", 1, 8'h41, 0, 0, 0);
        step("mid_b", 1, 8'h42, 0, 0, 0);
        step("mid_clrcv", 1, 8'h43, 1, 1, 0);
        step("mid_after", 0, 8'h00, 0, 0, 0);

        step("rp_a", 1, 8'h41, 1, 0, 0);
        step("rp_rst", 0, 8'h00, 0, 0, 1);
        step("rp_after", 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            p   = int'($urandom_range(0, 9));
            c   = (p == 0) ? SP : (p == 1) ? BL : 8'($urandom_range(1, 255));
            cv  = ($urandom_range(0, 9) < 4);
            we  = ($urandom_range(0, 9) < 3);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 199) < 1);
            step("rand", cv, c, we, clr, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
